// File: rtl/lut_cluster_pkg.sv
// Shared types and sizing helpers for the scan-configured LUT cluster.
package lut_cluster_pkg;

  typedef enum logic [1:0] {
    UNCFG   = 2'd0,
    LOADING = 2'd1,
    ACTIVE  = 2'd2
  } cfg_state_t;

  // Config bits per LUT: 2**k truth-table bits plus one MODE bit.
  function automatic int unsigned cfg_l(input int unsigned k);
    return (32'd1 << k) + 32'd1;
  endfunction

  function automatic int unsigned cfg_bits(input int unsigned k, input int unsigned n);
    return n * cfg_l(k);
  endfunction

endpackage

// File: rtl/lut_cluster_cfg_cell.sv
// One K-input LUT with optional output flip-flop; silent until the cluster is active.
module lut_cell #(
  parameter int unsigned K = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [(2**K)-1:0]  tt,
  input  logic               mode,
  input  logic [K-1:0]       lut_in,
  input  logic               ce,
  input  logic               active,
  input  logic               clr,
  output logic               lut_out
);

  logic comb_c;
  logic ff_q;

  assign comb_c = tt[lut_in];

  // clr marks the edge that enters LOADING and outranks any capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff_q <= 1'b0;
    end else if (clr) begin
      ff_q <= 1'b0;
    end else if (ce && active) begin
      ff_q <= comb_c;
    end
  end

  assign lut_out = active ? (mode ? ff_q : comb_c) : 1'b0;

endmodule

// File: rtl/lut_cluster_cfg.sv
// Cluster of N K-input LUTs loaded through a serial scan chain with load status flags.
module lut_cluster_cfg
  import lut_cluster_pkg::*;
#(
  parameter int unsigned K = 4,
  parameter int unsigned N = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cfg_load,
  input  logic           cfg_en,
  input  logic           cfg_in,
  output logic           cfg_out,
  output logic           cfg_done,
  output logic           cfg_err,
  input  logic           ce,
  input  logic [N*K-1:0] lut_in,
  output logic [N-1:0]   lut_out
);

  localparam int unsigned L        = cfg_l(K);
  localparam int unsigned CFG_BITS = cfg_bits(K, N);
  localparam int unsigned CW       = $clog2(CFG_BITS + 1);
  localparam int unsigned TTW      = 2**K;

  cfg_state_t            state_q;
  cfg_state_t            state_d;
  logic [CW-1:0]         cnt_q;
  logic [CFG_BITS-1:0]   cfg_q;
  logic                  err_q;
  logic                  shift_c;
  logic                  err_set_c;
  logic                  active_c;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= UNCFG;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a load pulse restarts from any state and wins over a shift.
  always_comb begin
    state_d = state_q;
    if (cfg_load) begin
      state_d = LOADING;
    end else begin
      case (state_q)
        UNCFG:   state_d = UNCFG;
        LOADING: begin
          if (cfg_en && (cnt_q == CW'(CFG_BITS - 1))) begin
            state_d = ACTIVE;
          end
        end
        ACTIVE:  state_d = ACTIVE;
        default: state_d = UNCFG;
      endcase
    end
  end

  // Per-state control decode.
  always_comb begin
    shift_c   = 1'b0;
    err_set_c = 1'b0;
    active_c  = 1'b0;
    case (state_q)
      LOADING: shift_c = cfg_en && !cfg_load;
      ACTIVE: begin
        active_c  = 1'b1;
        err_set_c = cfg_en && !cfg_load;
      end
      default: err_set_c = cfg_en && !cfg_load;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cfg_load) begin
      cnt_q <= '0;
    end else if (shift_c) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // A restart keeps old contents; new shifts simply overwrite them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_q <= '0;
    end else if (shift_c) begin
      cfg_q <= {cfg_q[CFG_BITS-2:0], cfg_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (cfg_load) begin
      err_q <= 1'b0;
    end else if (err_set_c) begin
      err_q <= 1'b1;
    end
  end

  assign cfg_out  = cfg_q[CFG_BITS-1];
  assign cfg_done = active_c;
  assign cfg_err  = err_q;

  for (genvar i = 0; i < N; i++) begin : g_cell
    lut_cell #(.K(K)) u_cell (
      .clk     (clk),
      .rst_n   (rst_n),
      .tt      (cfg_q[i*L +: TTW]),
      .mode    (cfg_q[i*L + TTW]),
      .lut_in  (lut_in[i*K +: K]),
      .ce      (ce),
      .active  (active_c),
      .clr     (cfg_load),
      .lut_out (lut_out[i])
    );
  end

endmodule

// File: tb/tb_lut_cluster_cfg.sv
// Scoreboard bench for lut_cluster_cfg at K=2, N=2 (10 config bits).
module tb_lut_cluster_cfg;

  localparam int unsigned K  = 2;
  localparam int unsigned N  = 2;
  localparam int unsigned L  = 5;
  localparam int unsigned CB = 10;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           cfg_load;
  logic           cfg_en;
  logic           cfg_in;
  logic           cfg_out;
  logic           cfg_done;
  logic           cfg_err;
  logic           ce;
  logic [N*K-1:0] lut_in;
  logic [N-1:0]   lut_out;

  lut_cluster_cfg #(.K(K), .N(N)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cfg_load (cfg_load),
    .cfg_en   (cfg_en),
    .cfg_in   (cfg_in),
    .cfg_out  (cfg_out),
    .cfg_done (cfg_done),
    .cfg_err  (cfg_err),
    .ce       (ce),
    .lut_in   (lut_in),
    .lut_out  (lut_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         done;
    logic         err;
    logic         co;
    logic [N-1:0] out;
  } exp_t;

  exp_t sbq[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model of the cluster.
  logic [CB-1:0] mq;
  int            mst;
  int            mcnt;
  logic          merr;
  logic [N-1:0]  mff;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  function automatic logic [N-1:0] mout();
    logic [N-1:0] r;
    logic [3:0]   tt;
    logic [1:0]   idx;
    for (int i = 0; i < N; i++) begin
      tt   = mq[i*L +: 4];
      idx  = lut_in[i*K +: K];
      r[i] = (mst == 2) ? (mq[i*L+4] ? mff[i] : tt[idx]) : 1'b0;
    end
    return r;
  endfunction

  task automatic push_exp();
    exp_t e;
    e.done = (mst == 2);
    e.err  = merr;
    e.co   = mq[CB-1];
    e.out  = mout();
    sbq.push_back(e);
  endtask

  task automatic pop_cmp(input string tag);
    exp_t e;
    if (sbq.size() == 0) begin
      check({tag, ".sbq_empty"}, 32'd1, 32'd0);
    end else begin
      e = sbq.pop_front();
      check({tag, ".done"}, 32'(cfg_done), 32'(e.done));
      check({tag, ".err"},  32'(cfg_err),  32'(e.err));
      check({tag, ".cout"}, 32'(cfg_out),  32'(e.co));
      check({tag, ".out"},  32'(lut_out),  32'(e.out));
    end
  endtask

  // One clock with the given control inputs; model advances with the same edge.
  task automatic cycle(input logic ld, input logic en, input logic din, input string tag);
    logic [N-1:0] nff;
    logic [3:0]   tt;
    cfg_load = ld;
    cfg_en   = en;
    cfg_in   = din;
    nff = mff;
    if (mst == 2 && ce) begin
      for (int i = 0; i < N; i++) begin
        tt     = mq[i*L +: 4];
        nff[i] = tt[lut_in[i*K +: K]];
      end
    end
    if (ld) begin
      mst = 1; mcnt = 0; merr = 1'b0; nff = '0;
    end else if (en) begin
      if (mst == 1) begin
        mq = {mq[CB-2:0], din};
        mcnt++;
        if (mcnt == CB) mst = 2;
      end else begin
        merr = 1'b1;
      end
    end
    mff = nff;
    @(posedge clk); #1;
    cfg_load = 1'b0;
    cfg_en   = 1'b0;
    push_exp();
    pop_cmp(tag);
  endtask

  task automatic set_in(input logic [N*K-1:0] v, input logic ce_v, input string tag);
    lut_in = v;
    ce     = ce_v;
    #1;
    push_exp();
    pop_cmp(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #3;
    mq = '0; mst = 0; mcnt = 0; merr = 1'b0; mff = '0;
    push_exp();
    pop_cmp(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic load_word(input logic [CB-1:0] w, input string tag);
    cycle(1'b1, 1'b0, 1'b0, {tag, ".ld"});
    for (int b = CB - 1; b >= 0; b--) cycle(1'b0, 1'b1, w[b], tag);
  endtask

  logic [CB-1:0] w2 = 10'b0_0110_0_1000;
  logic [CB-1:0] w3 = 10'b0_0110_1_0110;
  logic [CB-1:0] w5 = 10'b1_0110_0_1000;
  logic [N-1:0]  held;

  initial begin
    rst_n = 1'b0; cfg_load = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0;
    ce = 1'b0; lut_in = '0;
    do_reset("por");

    // Reset in the middle of a load.
    cycle(1'b1, 1'b0, 1'b0, "t1.ld");
    for (int s = 0; s < 4; s++) cycle(1'b0, 1'b1, 1'b1, "t1.sh");
    do_reset("t1.rst");
    check("t1.rst_done", 32'(cfg_done), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, "t1.uncfg_en");
    check("t1.uncfg_err", 32'(cfg_err), 32'd1);

    // Combinational AND / XOR.
    cycle(1'b1, 1'b0, 1'b0, "t2.ld");
    for (int b = CB - 1; b >= 1; b--) cycle(1'b0, 1'b1, w2[b], "t2.sh");
    check("t2.done9", 32'(cfg_done), 32'd0);
    cycle(1'b0, 1'b1, w2[0], "t2.sh10");
    check("t2.done10", 32'(cfg_done), 32'd1);
    set_in(4'b0101, 1'b0, "t2.in0101");
    check("t2.xor01", 32'(lut_out), 32'b10);
    set_in(4'b1111, 1'b0, "t2.in1111");
    check("t2.xor11", 32'(lut_out), 32'b01);

    // Registered LUT0.
    set_in(4'b0000, 1'b0, "t3.pre");
    load_word(w3, "t3.sh");
    set_in(4'b0000, 1'b1, "t3.in00");
    cycle(1'b0, 1'b0, 1'b0, "t3.cap00");
    set_in(4'b0001, 1'b1, "t3.in01");
    check("t3.before_edge", 32'(lut_out[0]), 32'd0);
    cycle(1'b0, 1'b0, 1'b0, "t3.cap01");
    check("t3.rise", 32'(lut_out[0]), 32'd1);
    set_in(4'b0000, 1'b0, "t3.ce0");
    cycle(1'b0, 1'b0, 1'b0, "t3.hold");
    check("t3.hold", 32'(lut_out[0]), 32'd1);

    // Shift while ACTIVE.
    held = lut_out;
    cycle(1'b0, 1'b1, 1'b1, "t4.en");
    check("t4.err", 32'(cfg_err), 32'd1);
    check("t4.out", 32'(lut_out), 32'(2'b01));
    cycle(1'b1, 1'b0, 1'b0, "t4.ld");
    check("t4.err_clr", 32'(cfg_err), 32'd0);
    check("t4.done_clr", 32'(cfg_done), 32'd0);

    // Load/shift collision mid-load.
    for (int s = 0; s < 3; s++) cycle(1'b0, 1'b1, 1'b1, "t5.sh");
    cycle(1'b1, 1'b1, 1'b0, "t5.collide");
    check("t5.coll_out", 32'(cfg_out), 32'd1);
    check("t5.coll_err", 32'(cfg_err), 32'd0);
    for (int b = CB - 1; b >= 1; b--) cycle(1'b0, 1'b1, w5[b], "t5.sh");
    check("t5.done9", 32'(cfg_done), 32'd0);
    cycle(1'b0, 1'b1, w5[0], "t5.sh10");
    check("t5.done10", 32'(cfg_done), 32'd1);

    // Chain out: first bit at the tail, then the rest in order.
    check("t6.chain0", 32'(cfg_out), 32'(w5[9]));
    cycle(1'b1, 1'b0, 1'b0, "t6.ld");
    for (int s = 1; s <= 3; s++) begin
      cycle(1'b0, 1'b1, 1'b0, "t6.sh");
      check($sformatf("t6.chain%0d", s), 32'(cfg_out), 32'(w5[9-s]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
